pong_game_ctrl: RTL and testbench

Central game sequencer for the Pong top level. It owns the game state machine, both players' scores, the match countdown and the serve and game-over delays. It also generates the freeze and serve controls for the ball/paddle engine. It sits between the debounced start button, the 1 Hz tick divider and the ball engine's miss flags, and feeds the dot-matrix score display, the seven-segment timer display and the ball engine.

---
 rtl/pong_game_ctrl_pkg.sv | 23 ++
 rtl/pong_game_ctrl_match_timer.sv | 46 ++++
 rtl/pong_game_ctrl.sv | 138 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the Pong game sequencer: state encodings, winner codes
// and BCD digit limits used by the match timer.
package pong_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [3:0] SEC2_MAX = 4'd9;
    localparam logic [3:0] SEC1_MAX = 4'd5;

    localparam int CNT_W = 4;

endpackage

// File: rtl/pong_game_ctrl_match_timer.sv
// BCD match countdown min:sec1 sec2. Loads MATCH_MIN:00, decrements one second
// per dec pulse and holds at 0:00.
module match_timer
    import pong_game_ctrl_pkg::*;
#(
    parameter int MATCH_MIN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] min,
    output logic [3:0] sec1,
    output logic [3:0] sec2,
    output logic       zero
);

    localparam logic [3:0] MIN_INIT = 4'(MATCH_MIN);

    assign zero = (min == 4'd0) && (sec1 == 4'd0) && (sec2 == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min  <= MIN_INIT;
            sec1 <= 4'd0;
            sec2 <= 4'd0;
        end else if (load) begin
            min  <= MIN_INIT;
            sec1 <= 4'd0;
            sec2 <= 4'd0;
        end else if (dec && !zero) begin
            // ones digit borrows from tens, tens borrows from minutes
            if (sec2 != 4'd0) begin
                sec2 <= sec2 - 4'd1;
            end else if (sec1 != 4'd0) begin
                sec2 <= SEC2_MAX;
                sec1 <= sec1 - 4'd1;
            end else begin
                sec2 <= SEC2_MAX;
                sec1 <= SEC1_MAX;
                min  <= min - 4'd1;
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns the game FSM, scores, winner and the serve/over
// delays, and drives stop/serve to the ball engine.
//
// state | meaning
// IDLE  | waiting for start edge; scores, winner and timer held cleared
// SERVE | serve pulse on entry, waits SERVE_TICKS ticks, timer frozen
// PLAY  | ball live, timer counts down, misses score
// POINT | one-cycle score settle; decides SERVE or OVER
// OVER  | winner latched, waits OVER_TICKS ticks then back to IDLE
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int MATCH_MIN   = 3,
    parameter int SERVE_TICKS = 2,
    parameter int OVER_TICKS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       miss1,
    input  logic       miss2,
    output logic       stop,
    output logic       serve,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] min,
    output logic [3:0] sec1,
    output logic [3:0] sec2,
    output logic [2:0] state,
    output logic [1:0] winner
);

    localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_TICKS - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic             start_q;
    logic             start_rise;
    logic [CNT_W-1:0] dly_cnt;
    logic             add1;
    logic             add2;
    logic             timer_load;
    logic             timer_dec;
    logic             timer_zero;

    assign start_rise = start_btn & ~start_q;
    assign stop       = (cur_state != ST_PLAY);
    assign state      = cur_state;

    always_comb begin
        nxt_state = cur_state;
        add1      = 1'b0;
        add2      = 1'b0;
        case (cur_state)
            ST_IDLE:  if (start_rise) nxt_state = ST_SERVE;
            ST_SERVE: if (tick && dly_cnt == SERVE_LAST) nxt_state = ST_PLAY;
            ST_PLAY: begin
                if (miss1) begin
                    add2      = 1'b1;
                    nxt_state = ST_POINT;
                end else if (miss2) begin
                    add1      = 1'b1;
                    nxt_state = ST_POINT;
                end else if (timer_zero) begin
                    nxt_state = ST_OVER;
                end
            end
            ST_POINT: begin
                if (score1 == WIN_VAL || score2 == WIN_VAL || timer_zero)
                    nxt_state = ST_OVER;
                else
                    nxt_state = ST_SERVE;
            end
            ST_OVER:  if (tick && dly_cnt == OVER_LAST) nxt_state = ST_IDLE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    // a tick on the edge that lands in PLAY is spent on the timer; otherwise it is dropped
    assign timer_load = (nxt_state == ST_IDLE);
    assign timer_dec  = tick && (nxt_state == ST_PLAY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= ST_IDLE;
            start_q   <= 1'b1;
            dly_cnt   <= '0;
            serve     <= 1'b0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            winner    <= WIN_NONE;
        end else begin
            cur_state <= nxt_state;
            start_q   <= start_btn;
            serve     <= (nxt_state == ST_SERVE) && (cur_state != ST_SERVE);

            if (nxt_state != cur_state)
                dly_cnt <= '0;
            else if (tick)
                dly_cnt <= dly_cnt + 1'b1;

            if (nxt_state == ST_IDLE) begin
                score1 <= 4'd0;
                score2 <= 4'd0;
                winner <= WIN_NONE;
            end else begin
                if (add1) score1 <= score1 + 4'd1;
                if (add2) score2 <= score2 + 4'd1;
                if (nxt_state == ST_OVER && cur_state != ST_OVER) begin
                    if (score1 > score2)
                        winner <= WIN_P1;
                    else if (score2 > score1)
                        winner <= WIN_P2;
                    else
                        winner <= WIN_DRAW;
                end
            end
        end
    end

    match_timer #(
        .MATCH_MIN (MATCH_MIN)
    ) u_match_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .min  (min),
        .sec1 (sec1),
        .sec2 (sec2),
        .zero (timer_zero)
    );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios plus random play
// compared against a game-rules reference model.
module tb_pong_game_ctrl;

    localparam int WIN_SCORE   = 9;
    localparam int MATCH_MIN   = 1;
    localparam int SERVE_TICKS = 2;
    localparam int OVER_TICKS  = 2;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start_btn = 1'b1;
    logic       miss1 = 1'b0;
    logic       miss2 = 1'b0;
    logic       stop;
    logic       serve;
    logic [3:0] score1, score2, min, sec1, sec2;
    logic [2:0] state;
    logic [1:0] winner;

    int total = 0;
    int bad = 0;

    // reference model: game rules with the clock as total seconds left
    int m_state, m_s1, m_s2, m_secs, m_cnt, m_winner;
    bit m_serve, m_start_q;

    pong_game_ctrl #(
        .WIN_SCORE   (WIN_SCORE),
        .MATCH_MIN   (MATCH_MIN),
        .SERVE_TICKS (SERVE_TICKS),
        .OVER_TICKS  (OVER_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start_btn (start_btn),
        .miss1     (miss1),
        .miss2     (miss2),
        .stop      (stop),
        .serve     (serve),
        .score1    (score1),
        .score2    (score2),
        .min       (min),
        .sec1      (sec1),
        .sec2      (sec2),
        .state     (state),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state   = S_IDLE;
        m_s1      = 0;
        m_s2      = 0;
        m_secs    = MATCH_MIN * 60;
        m_cnt     = 0;
        m_winner  = 0;
        m_serve   = 1'b0;
        m_start_q = 1'b1;
    endtask

    task automatic model_edge();
        int  nxt;
        bit  rise;
        if (!rst) begin
            model_reset();
            return;
        end
        rise      = start_btn && !m_start_q;
        m_start_q = start_btn;
        nxt       = m_state;
        case (m_state)
            S_IDLE:  if (rise) nxt = S_SERVE;
            S_SERVE: if (tick && m_cnt + 1 == SERVE_TICKS) nxt = S_PLAY;
            S_PLAY: begin
                if (miss1) begin m_s2++; nxt = S_POINT; end
                else if (miss2) begin m_s1++; nxt = S_POINT; end
                else if (m_secs == 0) nxt = S_OVER;
            end
            S_POINT: nxt = (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE || m_secs == 0) ? S_OVER : S_SERVE;
            default: if (tick && m_cnt + 1 == OVER_TICKS) nxt = S_IDLE;
        endcase
        if (tick && nxt == S_PLAY && m_secs > 0) m_secs--;
        if (nxt == S_OVER && m_state != S_OVER)
            m_winner = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
        if (nxt == S_IDLE) begin
            m_s1 = 0; m_s2 = 0; m_winner = 0; m_secs = MATCH_MIN * 60;
        end
        m_serve = (nxt == S_SERVE) && (m_state != S_SERVE);
        m_cnt   = (nxt != m_state) ? 0 : (tick ? m_cnt + 1 : m_cnt);
        m_state = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic start_game();
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    task automatic go_play();
        for (int n = 0; n < 10 && m_state != S_PLAY; n++) pulse_tick();
    endtask

    task automatic finish_over();
        for (int n = 0; n < 10 && m_state != S_IDLE; n++) pulse_tick();
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({state, stop, serve, winner} !== {3'd0, 1'b1, 1'b0, 2'b00}) begin
            bad++;
            $display("FAIL reset_ctrl: state=%0d stop=%0b serve=%0b winner=%0b, required 0 1 0 00", state, stop, serve, winner);
        end
        total++;
        if ({score1, score2, min, sec1, sec2} !== {4'd0, 4'd0, 4'(MATCH_MIN), 4'd0, 4'd0}) begin
            bad++;
            $display("FAIL reset_vals: s1=%0d s2=%0d timer=%0d:%0d%0d, required 0 0 %0d:00", score1, score2, min, sec1, sec2, MATCH_MIN);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step();
        step();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL held_start: state=%0d, required 0", state);
        end
    endtask

    task automatic test_start();
        start_game();
        total++;
        if (state !== 3'd1 || serve !== 1'b1 || stop !== 1'b1) begin
            bad++;
            $display("FAIL start_serve: state=%0d serve=%0b stop=%0b, required 1 1 1", state, serve, stop);
        end
        step();
        total++;
        if (serve !== 1'b0 || state !== 3'd1) begin
            bad++;
            $display("FAIL serve_pulse: state=%0d serve=%0b, required 1 0", state, serve);
        end
        pulse_tick();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL serve_wait: state=%0d, required 1", state);
        end
        pulse_tick();
        total++;
        if (state !== 3'd2 || stop !== 1'b0) begin
            bad++;
            $display("FAIL enter_play: state=%0d stop=%0b, required 2 0", state, stop);
        end
    endtask

    task automatic test_miss_hold();
        miss2 = 1'b1;
        step();
        total++;
        if (state !== 3'd3 || score1 !== 4'd1 || score2 !== 4'd0) begin
            bad++;
            $display("FAIL miss_point: state=%0d s1=%0d s2=%0d, required 3 1 0", state, score1, score2);
        end
        step();
        total++;
        if (state !== 3'd1 || serve !== 1'b1) begin
            bad++;
            $display("FAIL point_serve: state=%0d serve=%0b, required 1 1", state, serve);
        end
        for (int i = 0; i < 8; i++) step();
        miss2 = 1'b0;
        total++;
        if (score1 !== 4'd1 || score2 !== 4'd0) begin
            bad++;
            $display("FAIL miss_once: s1=%0d s2=%0d, required 1 0", score1, score2);
        end
        go_play();
    endtask

    task automatic test_double_miss();
        miss1 = 1'b1;
        miss2 = 1'b1;
        step();
        miss1 = 1'b0;
        miss2 = 1'b0;
        total++;
        if (score1 !== 4'd1 || score2 !== 4'd1 || state !== 3'd3) begin
            bad++;
            $display("FAIL double_miss: s1=%0d s2=%0d state=%0d, required 1 1 3", score1, score2, state);
        end
        step();
        go_play();
    endtask

    task automatic test_win();
        for (int n = 0; n < 20 && m_s1 < WIN_SCORE; n++) begin
            go_play();
            miss2 = 1'b1;
            step();
            miss2 = 1'b0;
            step();
        end
        total++;
        if (state !== 3'd4 || winner !== 2'b01 || score1 !== 4'd9 || stop !== 1'b1) begin
            bad++;
            $display("FAIL win_p1: state=%0d winner=%0b s1=%0d stop=%0b, required 4 01 9 1", state, winner, score1, stop);
        end
        pulse_tick();
        total++;
        if (state !== 3'd4 || score1 !== 4'd9) begin
            bad++;
            $display("FAIL over_hold: state=%0d s1=%0d, required 4 9", state, score1);
        end
        pulse_tick();
        total++;
        if ({state, score1, score2, winner} !== {3'd0, 4'd0, 4'd0, 2'b00} || min !== 4'(MATCH_MIN)) begin
            bad++;
            $display("FAIL over_idle: state=%0d s1=%0d s2=%0d winner=%0b min=%0d, required 0 0 0 00 %0d", state, score1, score2, winner, min, MATCH_MIN);
        end
    endtask

    task automatic test_timeout();
        bit seen_059 = 1'b0;
        start_game();
        go_play();
        for (int n = 0; n < 80 && m_state != S_OVER; n++) begin
            if (min == 4'd0 && sec1 == 4'd5 && sec2 == 4'd9) seen_059 = 1'b1;
            pulse_tick();
            total++;
            if ({min, sec1, sec2} !== {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10)}) begin
                bad++;
                $display("FAIL timer_count: got %0d:%0d%0d, required %0d s", min, sec1, sec2, m_secs);
            end
        end
        total++;
        if (!seen_059) begin
            bad++;
            $display("FAIL timer_059: 0:59 never shown, required shown");
        end
        total++;
        if (state !== 3'd4 || winner !== 2'b11 || {min, sec1, sec2} !== 12'h000) begin
            bad++;
            $display("FAIL timeout_draw: state=%0d winner=%0b timer=%0d:%0d%0d, required 4 11 0:00", state, winner, min, sec1, sec2);
        end
        finish_over();
    endtask

    task automatic test_reset_mid();
        start_game();
        go_play();
        miss2 = 1'b1;
        step();
        miss2 = 1'b0;
        step();
        go_play();
        total++;
        if (state !== 3'd2 || score1 !== 4'd1) begin
            bad++;
            $display("FAIL pre_reset: state=%0d s1=%0d, required 2 1", state, score1);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({state, stop, serve, winner, score1, score2} !== {3'd0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0} ||
            {min, sec1, sec2} !== {4'(MATCH_MIN), 4'd0, 4'd0}) begin
            bad++;
            $display("FAIL async_reset: state=%0d stop=%0b s1=%0d timer=%0d:%0d%0d, required 0 1 0 %0d:00", state, stop, score1, min, sec1, sec2, MATCH_MIN);
        end
        step();
        rst = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            tick  = ($urandom_range(0, 3) == 0);
            miss1 = ($urandom_range(0, 15) == 0);
            miss2 = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            step();
            total++;
            if (state !== 3'(m_state) || stop !== (m_state != S_PLAY) || serve !== m_serve) begin
                bad++;
                $display("FAIL rnd_ctrl[%0d]: state=%0d stop=%0b serve=%0b, required %0d %0b %0b", i, state, stop, serve, m_state, m_state != S_PLAY, m_serve);
            end
            total++;
            if (score1 !== 4'(m_s1) || score2 !== 4'(m_s2) || winner !== 2'(m_winner)) begin
                bad++;
                $display("FAIL rnd_score[%0d]: s1=%0d s2=%0d winner=%0d, required %0d %0d %0d", i, score1, score2, winner, m_s1, m_s2, m_winner);
            end
            total++;
            if ({min, sec1, sec2} !== {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10)}) begin
                bad++;
                $display("FAIL rnd_timer[%0d]: got %0d:%0d%0d, required %0d s", i, min, sec1, sec2, m_secs);
            end
        end
        tick  = 1'b0;
        miss1 = 1'b0;
        miss2 = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_miss_hold();
        test_double_miss();
        test_win();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
